// File: rtl/uart_rx_ex.sv
// Parametrised UART receiver: 2-flop synchronizer, 3-sample majority voting,
// false-start rejection, parity/framing/break detection, ready/valid buffer.
module uart_rx_ex #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 4000000,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] SAMP_A   = CW'(DIV/2 - 1);
  localparam logic [CW-1:0] SAMP_B   = CW'(DIV/2);
  localparam logic [CW-1:0] DECIDE   = CW'(DIV/2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rs_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 break_q, break_d;

  logic maj, at_dec, at_end, par_x, ferr_now, brk_cond;

  assign maj      = (s0_q & s1_q) | (s0_q & rs_q) | (s1_q & rs_q);
  assign at_dec   = (cnt_q == DECIDE);
  assign at_end   = (cnt_q == CNT_LAST);
  assign par_x    = ^{shift_q, maj};
  assign ferr_now = ferr_pend_q | ~maj;
  assign brk_cond = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      par_bit_q   <= 1'b0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
      break_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      par_bit_q   <= par_bit_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      overrun_q   <= overrun_d;
      break_q     <= break_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = at_end ? '0 : cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    s0_d        = (cnt_q == SAMP_A) ? rs_q : s0_q;
    s1_d        = (cnt_q == SAMP_B) ? rs_q : s1_q;
    par_bit_d   = par_bit_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    overrun_d   = 1'b0;
    break_d     = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rs_q) state_d = S_START;
      end
      S_START: begin
        if (at_dec && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (at_end) begin
          state_d     = S_DATA;
          bit_idx_d   = '0;
          stop_idx_d  = 1'b0;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end
      end
      S_DATA: begin
        if (at_dec) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_idx_q == BIT_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (at_dec) begin
          par_bit_d   = maj;
          perr_pend_d = (PARITY == 1) ? ~par_x : par_x;
        end
        if (at_end) state_d = S_STOP;
      end
      S_STOP: begin
        // Frame ends at the last stop bit's decision so the next start edge is not missed.
        if (at_dec) begin
          if (!stop_idx_q && brk_cond) begin
            break_d = 1'b1;
            state_d = S_WAIT_HIGH;
            cnt_d   = '0;
          end else if (stop_idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              perr_d  = perr_pend_q;
              ferr_d  = ferr_now;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            ferr_pend_d = ferr_now;
          end
        end else if (at_end) begin
          stop_idx_d = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rs_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign break_det  = break_q;

endmodule

// File: tb/tb_uart_rx_ex.sv
// Directed bench for uart_rx_ex: an 8N1 instance and a 7E1 instance, DIV=25.
module tb_uart_rx_ex;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx8, rx7, ready8, ready7;
  logic [7:0] data8;
  logic [6:0] data7;
  logic       valid8, perr8, ferr8, ovr8, brk8;
  logic       valid7, perr7, ferr7, ovr7, brk7;

  int checks = 0;
  int errors = 0;

  logic [9:0] w8 [0:63];
  logic [8:0] w7 [0:63];
  int nw8 = 0, nw7 = 0, nov8 = 0, nov7 = 0, nbrk8 = 0, nbrk7 = 0;
  int b_w, b_ov, b_brk;

  always #5 clk = ~clk;

  uart_rx_ex u8 (
    .clk(clk), .rst_n(rst_n), .rx(rx8), .data(data8), .valid(valid8), .ready(ready8),
    .parity_err(perr8), .frame_err(ferr8), .overrun(ovr8), .break_det(brk8)
  );

  uart_rx_ex #(.DATA_BITS(7), .PARITY(2)) u7 (
    .clk(clk), .rst_n(rst_n), .rx(rx7), .data(data7), .valid(valid7), .ready(ready7),
    .parity_err(perr7), .frame_err(ferr7), .overrun(ovr7), .break_det(brk7)
  );

  // Records accepted words and event pulses as seen by the consumer.
  always @(negedge clk) begin
    if (valid8 && ready8 && nw8 < 64) begin
      w8[nw8] = {perr8, ferr8, data8};
      nw8++;
    end
    if (valid7 && ready7 && nw7 < 64) begin
      w7[nw7] = {perr7, ferr7, data7};
      nw7++;
    end
    if (ovr8) nov8++;
    if (ovr7) nov7++;
    if (brk8) nbrk8++;
    if (brk7) nbrk7++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int which, input logic v);
    if (which == 0) rx8 = v;
    else rx7 = v;
    wait_clks(25);
  endtask

  task automatic send8(input logic [7:0] d, input logic stop_v);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(0, d[i]);
    drive_bit(0, stop_v);
    rx8 = 1'b1;
  endtask

  task automatic send7(input logic [6:0] d, input logic p);
    drive_bit(1, 1'b0);
    for (int i = 0; i < 7; i++) drive_bit(1, d[i]);
    drive_bit(1, p);
    drive_bit(1, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid8"}, {31'd0, valid8}, 32'd0);
    check({tag, "_data8"},  {24'd0, data8},  32'd0);
    check({tag, "_flags8"}, {28'd0, perr8, ferr8, ovr8, brk8}, 32'd0);
    check({tag, "_valid7"}, {31'd0, valid7}, 32'd0);
    check({tag, "_data7"},  {25'd0, data7},  32'd0);
    check({tag, "_flags7"}, {28'd0, perr7, ferr7, ovr7, brk7}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rx8 = 1'b1; rx7 = 1'b1; ready8 = 1'b1; ready7 = 1'b1;
    wait_clks(4);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_clks(10);

    // Back-to-back 8N1 frames.
    b_w = nw8;
    send8(8'hA5, 1'b1);
    send8(8'h3C, 1'b1);
    wait_clks(20);
    check("b2b_count", nw8 - b_w, 2);
    check("b2b_word0", {22'd0, w8[b_w]}, 32'h0A5);
    check("b2b_word1", {22'd0, w8[b_w+1]}, 32'h03C);

    // 7E1: correct then wrong parity on 0x41.
    b_w = nw7;
    send7(7'h41, 1'b0);
    send7(7'h41, 1'b1);
    wait_clks(20);
    check("par_count", nw7 - b_w, 2);
    check("par_good",  {23'd0, w7[b_w]}, 32'h041);
    check("par_bad",   {23'd0, w7[b_w+1]}, 32'h141);

    // Stop bit forced low.
    b_w = nw8;
    send8(8'h55, 1'b0);
    wait_clks(80);
    check("frame_count", nw8 - b_w, 1);
    check("frame_word",  {22'd0, w8[b_w]}, 32'h155);

    // Short low glitch.
    b_w = nw8;
    rx8 = 1'b0;
    wait_clks(5);
    rx8 = 1'b1;
    wait_clks(60);
    check("glitch_count", nw8 - b_w, 0);
    check("glitch_valid", {31'd0, valid8}, 32'd0);

    // Overrun with consumer stalled.
    ready8 = 1'b0;
    b_ov = nov8;
    send8(8'h11, 1'b1);
    send8(8'h22, 1'b1);
    wait_clks(20);
    check("ovr_valid", {31'd0, valid8}, 32'd1);
    check("ovr_data",  {24'd0, data8}, 32'h11);
    check("ovr_pulses", nov8 - b_ov, 1);
    b_w = nw8;
    ready8 = 1'b1;
    wait_clks(1);
    check("ovr_drop_valid", {31'd0, valid8}, 32'd0);
    check("ovr_accept_word", {22'd0, w8[b_w]}, 32'h011);
    b_w = nw8;
    send8(8'h33, 1'b1);
    wait_clks(20);
    check("after_ovr_count", nw8 - b_w, 1);
    check("after_ovr_word", {22'd0, w8[b_w]}, 32'h033);
    check("after_ovr_data", {24'd0, data8}, 32'h33);

    // Break: line low for three frame times.
    b_w = nw8; b_brk = nbrk8; b_ov = nov8;
    rx8 = 1'b0;
    wait_clks(750);
    rx8 = 1'b1;
    wait_clks(60);
    check("brk_pulses", nbrk8 - b_brk, 1);
    check("brk_no_word", nw8 - b_w, 0);
    check("brk_no_ovr", nov8 - b_ov, 0);
    send8(8'h7E, 1'b1);
    wait_clks(20);
    check("post_brk_count", nw8 - b_w, 1);
    check("post_brk_word", {22'd0, w8[b_w]}, 32'h07E);

    // Reset in the middle of the data bits.
    b_w = nw8;
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rst_n = 1'b0;
    rx8 = 1'b1;
    wait_clks(3);
    check_all_zero("midrst");
    rst_n = 1'b1;
    wait_clks(30);
    send8(8'h99, 1'b1);
    wait_clks(20);
    check("midrst_count", nw8 - b_w, 1);
    check("midrst_word", {22'd0, w8[b_w]}, 32'h099);
    check("midrst_brk", nbrk8 - b_brk, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ex.md
# uart_rx_ex

Parametrised UART receiver: the next generation of the fixed 8N1 receiver in the host-to-DDS serial link. Adds configurable data width, parity and stop bits, 3-sample majority voting, false-start rejection, parity/framing/break detection, and a ready/valid output buffer with overrun reporting. Sits between the board UART pin and the command parser that programs the DDS/SSB registers.

## Interface
- CLK_FREQ, 100000000: system clock in Hz.
- BAUD_RATE, 4000000: line rate; DIV = CLK_FREQ/BAUD_RATE (integer truncation), DIV >= 8 required.
- DATA_BITS, 8: 5..9, LSB first.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial line, idle high.
- data  out  DATA_BITS  received word; valid only while valid=1.
- valid  out  1  word available; held until accepted.
- ready  in  1  consumer accepts when valid && ready.
- parity_err  out  1  parity mismatch for the word in data; 0 when PARITY=0.
- frame_err  out  1  a stop bit sampled 0 for the word in data.
- overrun  out  1  one-cycle pulse: completed frame dropped because the buffer was full.
- break_det  out  1  one-cycle pulse: break condition detected.

## Operation
- rx passes a 2-flop synchronizer, both flops reset to 1; all logic uses the synchronized value rs.
- Bit timer cnt counts 0..DIV-1 per bit. Majority sample = 2-of-3 of rs at cnt = DIV/2-1, DIV/2, DIV/2+1; the bit decision is taken at cnt = DIV/2+1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: rs=0 -> START, cnt=0.
- START: majority 1 -> false start, back to IDLE (nothing reported). Majority 0 -> continue until cnt=DIV-1, then DATA, bit index 0.
- DATA: decision shifts into the shift register LSB-first; after DATA_BITS bits -> PARITY if PARITY!=0, else STOP.
- PARITY: odd requires XOR(data, p)=1; even requires 0; mismatch sets the pending parity flag.
- STOP: each stop bit is decided at its majority point; any 0 sets the pending frame flag. The frame completes at the decision of the last stop bit; the timer does not run out the rest of the bit, so the next start edge is caught.
- Completion, non-break: if the buffer is empty, or is emptying this cycle (valid && ready), load data/parity_err/frame_err and set valid. Otherwise pulse overrun, drop the frame and keep the old contents. Then IDLE.
- Break: all data bits 0, parity bit (if any) 0, and the first stop bit 0. Pulse break_det, deliver nothing, go to WAIT_HIGH, and stay there until rs=1, then IDLE.
- Consumer: valid && ready clears valid on the next edge. parity_err and frame_err are cleared with valid.
- Reset (async, any state): state=IDLE, cnt=0, valid=0, data=0, parity_err=0, frame_err=0, overrun=0, break_det=0. A frame in flight is discarded and reception resumes on the next falling edge after release.

## Timing
- Start-edge detection latency: 2 clocks (synchronizer) + 1 clock (IDLE->START).
- valid, overrun and break_det are registered. They assert on the clock after the last stop bit's decision point, about (1 + DATA_BITS + P + STOP_BITS - 1)*DIV + DIV/2 + 5 clocks after the rx falling edge, where P = 1 if parity is enabled.
- Acceptance and completion on the same cycle: the new word loads, valid stays 1, and there is no overrun.
- Glitch rejection: a low pulse shorter than DIV/2 - 3 clocks never produces valid.
- Throughput: back-to-back frames at the exact baud rate are received with no loss while ready=1.

## Test plan
- 8N1, DIV=25, ready=1: send 0xA5 then 0x3C back-to-back -> valid pulses twice with data 0xA5 then 0x3C, all error flags 0.
- PARITY=2, DATA_BITS=7: send 0x41 with correct parity (0), then 0x41 with parity 1 -> first word parity_err=0, second word parity_err=1, data=0x41 both times.
- Stop bit forced 0 on 0x55 -> valid with frame_err=1, data=0x55. A 5-clock low glitch on idle rx -> no valid.
- ready=0: send 0x11 then 0x22 -> data stays 0x11, one overrun pulse. Raise ready -> valid drops next clock. Send 0x33 -> data=0x33.
- rx held low for 3 frame times -> exactly one break_det pulse, no valid. Release rx, send 0x7E -> data=0x7E.
- Assert rst_n=0 in the middle of DATA, then release and send 0x99 -> all outputs 0 during reset, then data=0x99 with no spurious word.
